// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous FIFO family.
`ifndef RESET_SIG
`define RESET_SIG rst
`endif

package fifo_pkg;

  // Occupancy runs 0..DEPTH, so it needs one bit more than a pointer.
  function automatic int unsigned count_width(int unsigned depth_nbits);
    return depth_nbits + 1;
  endfunction

endpackage

// File: rtl/sfifo_fwft.sv
// Single-clock first-word-fall-through FIFO: head entry always on dout, rd pops it.
`ifndef RESET_SIG
`define RESET_SIG rst
`endif

module sfifo_fwft
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEPTH_NBITS = 2
) (
  input  logic                   clk,
  input  logic                   `RESET_SIG,
  input  logic [WIDTH-1:0]       din,
  input  logic                   wr,
  input  logic                   rd,
  output logic [WIDTH-1:0]       dout,
  output logic [DEPTH_NBITS:0]   count,
  output logic [DEPTH_NBITS:0]   ncount,
  output logic                   full,
  output logic                   fullm1,
  output logic                   empty,
  output logic                   emptyp2
);

  localparam int unsigned CW    = count_width(DEPTH_NBITS);
  localparam int unsigned DEPTH = 2 ** DEPTH_NBITS;

  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [DEPTH_NBITS-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]          count_q, count_d;
  logic                   rd_eff, wr_eff;

  // Flags come from registered count only, so no rd/wr -> flag timing path.
  assign full    = (count_q == CW'(DEPTH));
  assign fullm1  = (count_q >= CW'(DEPTH - 1));
  assign empty   = (count_q == '0);
  assign emptyp2 = (count_q < CW'(2));

  // A pop frees the slot this edge, so a write to a full FIFO may pair with it.
  assign rd_eff = rd & ~empty;
  assign wr_eff = wr & (~full | rd_eff);

  always_comb begin
    count_d = count_q;
    if (wr_eff && !rd_eff) begin
      count_d = count_q + CW'(1);
    end else if (rd_eff && !wr_eff) begin
      count_d = count_q - CW'(1);
    end
  end

  assign ncount = count_d;
  assign count  = count_q;
  assign dout   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (`RESET_SIG) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (wr_eff) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (rd_eff) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sfifo_fwft.sv
// Directed scoreboard bench for sfifo_fwft (WIDTH=8, DEPTH=4).
`ifndef RESET_SIG
`define RESET_SIG rst
`endif

module tb_sfifo_fwft;

  localparam int Depth = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       wr  = 1'b0;
  logic       rd  = 1'b0;
  logic [7:0] dout;
  logic [2:0] count, ncount;
  logic       full, fullm1, empty, emptyp2;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb[$];

  sfifo_fwft #(
    .WIDTH       (8),
    .DEPTH_NBITS (2)
  ) dut (
    .clk        (clk),
    .`RESET_SIG (rst),
    .din        (din),
    .wr         (wr),
    .rd         (rd),
    .dout       (dout),
    .count      (count),
    .ncount     (ncount),
    .full       (full),
    .fullm1     (fullm1),
    .empty      (empty),
    .emptyp2    (emptyp2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare registered outputs with the queue model; dout only when a head exists.
  task automatic check_state(input bit dout_zero);
    int n;
    n = sb.size();
    chk("count", int'(count), n);
    chk("empty", int'(empty), int'(n == 0));
    chk("full", int'(full), int'(n == Depth));
    chk("fullm1", int'(fullm1), int'(n >= Depth - 1));
    chk("emptyp2", int'(emptyp2), int'(n < 2));
    if (n > 0) chk("dout", int'(dout), int'(sb[0]));
    else if (dout_zero) chk("dout_zero", int'(dout), 0);
  endtask

  task automatic step(input bit w, input logic [7:0] d, input bit r);
    int n, expn;
    bit re, we;
    wr = w; din = d; rd = r;
    #1;
    n    = sb.size();
    re   = r && (n > 0);
    we   = w && ((n < Depth) || re);
    expn = n + int'(we) - int'(re);
    chk("ncount", int'(ncount), expn);
    @(posedge clk);
    #1;
    if (re) void'(sb.pop_front());
    if (we) sb.push_back(d);
    wr = 1'b0; rd = 1'b0;
    check_state(1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_state(1'b1);
    chk("reset_ncount", int'(ncount), 0);

    // Fill to full, head visible one cycle after the first write.
    step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    step(1, 8'h33, 0);
    step(1, 8'h44, 0);
    step(1, 8'h55, 0);   // dropped while full
    step(1, 8'h66, 1);   // pop and push while full
    repeat (4) step(0, 8'h00, 1);
    step(0, 8'h00, 1);   // read when empty is ignored

    // rd & wr while empty: write only, no bypass.
    step(1, 8'hA5, 1);
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);

    // Steady count=2 across pointer wrap.
    step(1, 8'hB0, 0);
    step(1, 8'hB1, 0);
    for (int i = 0; i < 10; i++) step(1, 8'hC0 + 8'(i), 1);

    // A few mixed random operations.
    for (int i = 0; i < 20; i++) step(1'($urandom), 8'($urandom), 1'($urandom));

    // Bring count to 3, then reset with a concurrent write.
    while (sb.size() > 0) step(0, 8'h00, 1);
    step(1, 8'hD1, 0);
    step(1, 8'hD2, 0);
    step(1, 8'hD3, 0);
    rst = 1'b1; wr = 1'b1; din = 8'h77;
    @(posedge clk);
    #1;
    rst = 1'b0; wr = 1'b0;
    sb.delete();
    check_state(1'b1);
    step(0, 8'h00, 0);
    chk("post_reset_dout", int'(dout), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
